exp_pipe: RTL

Pipelined, parametrised fixed-point e^x unit for the attention engine's softmax path. It accepts signed scores from the MAC and returns unsigned exponentials with saturation. Range reduction is x = n·ln2 + r, followed by the polynomial 1 + r + r²/2 and a shift by n. The unit has three register stages with valid/ready backpressure, a sideband tag, and a saturation flag.

---
 rtl/exp_pipe.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/exp_pipe.sv
// exp_pipe: fixed-point e^x for the softmax path, x = n*ln2 + r, e^r ~ 1 + r + r^2/2, then shift by n.
// Latency: three register stages; a beat presented in cycle c is on out_* in cycle c+3 (no stall).
// Backpressure: a stage loads when empty or draining; in_ready is combinational from out_ready and stage valids.
module exp_pipe #(
  parameter int W        = 8,
  parameter int FRAC     = 6,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 6,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_sat
);

  // Rounded fixed-point constants with FRAC fraction bits (92 and 44 at FRAC=6).
  localparam real SCALE = 2.0 ** FRAC;
  localparam int  LOG2E = $rtoi(1.4426950408889634 * SCALE + 0.5);
  localparam int  LN2   = $rtoi(0.6931471805599453 * SCALE + 0.5);

  // Widths chosen generously so no intermediate can wrap for any W/FRAC.
  localparam int TW = W + 2*FRAC + 3;       // x*LOG2E plus rounding half
  localparam int NW = W + 3;                // integer exponent n
  localparam int RW = W + FRAC + 5;         // residual r
  localparam int PW = 2*RW + 2;             // polynomial p including r^2
  localparam int D  = OUT_FRAC - FRAC;      // output fraction alignment
  localparam int YW = PW + OUT_W + D + 1;   // shifted result before clamp

  logic                    r_v1, r_v2, r_v3;
  logic signed [W-1:0]     r_x1;
  logic signed [NW-1:0]    r_n1, r_n2;
  logic signed [RW-1:0]    r_r2;
  logic [TAG_W-1:0]        r_tag1, r_tag2, r_tag3;
  logic [OUT_W-1:0]        r_dat3;
  logic                    r_sat3;

  logic                    w_rdy1, w_rdy2, w_rdy3;
  logic signed [TW-1:0]    w_t, w_tr;
  logic signed [NW-1:0]    w_n;
  logic signed [RW-1:0]    w_r;
  logic signed [PW-1:0]    w_sq, w_p;
  logic [PW-1:0]           w_pu, w_q;
  logic [YW-1:0]           w_y;
  logic signed [31:0]      w_n32;
  logic                    w_ovf, w_sat;
  logic [OUT_W-1:0]        w_dat;

  // Ready ripples back from the consumer; a stage may load if empty or if it drains this cycle.
  assign w_rdy3   = !r_v3 || out_ready;
  assign w_rdy2   = !r_v2 || w_rdy3;
  assign w_rdy1   = !r_v1 || w_rdy2;
  assign in_ready = w_rdy1;

  // Stage 1 datapath: n = round-half-up(x*log2(e)) via floor((t + half) >> 2FRAC).
  always_comb begin
    w_t  = TW'($signed(in_data)) * TW'(LOG2E);
    w_tr = w_t + (TW'(1) <<< (2*FRAC - 1));
    w_n  = NW'(w_tr >>> (2*FRAC));
  end

  // Stage 1 registers: capture x, n and tag when a valid beat is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_x1   <= '0;
      r_n1   <= '0;
      r_tag1 <= '0;
    end else if (w_rdy1) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_x1   <= $signed(in_data);
        r_n1   <= w_n;
        r_tag1 <= in_tag;
      end
    end
  end

  // Stage 2 datapath: residual r = x - n*ln2, exact in RW bits.
  always_comb begin
    w_r = RW'(r_x1) - RW'(r_n1) * RW'(LN2);
  end

  // Stage 2 registers: carry r, n and tag forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_r2   <= '0;
      r_n2   <= '0;
      r_tag2 <= '0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_r2   <= w_r;
        r_n2   <= r_n1;
        r_tag2 <= r_tag1;
      end
    end
  end

  // Stage 3 datapath: polynomial, shift by n (right shift truncates first), align, clamp.
  always_comb begin
    w_sq  = PW'(r_r2) * PW'(r_r2);
    w_p   = (PW'(1) <<< FRAC) + PW'(r_r2) + (w_sq >>> (FRAC + 1));
    w_pu  = w_p[PW-1] ? '0 : w_p;
    w_n32 = 32'(r_n2);
    w_ovf = 1'b0;
    w_q   = '0;
    w_y   = '0;
    if (w_n32 >= 0) begin
      // Any nonzero p shifted to or past OUT_W bits cannot fit, so flag it without building the wide value.
      if (w_n32 + D >= OUT_W) w_ovf = (w_pu != '0);
      else                    w_y   = YW'(w_pu) << (w_n32 + D);
    end else begin
      if (-w_n32 < PW) w_q = w_pu >> (-w_n32);
      w_y = YW'(w_q) << D;
    end
    w_sat = w_ovf || ((w_y >> OUT_W) != '0);
    w_dat = w_sat ? '1 : OUT_W'(w_y);
  end

  // Stage 3 registers: the output holding register; frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v3   <= 1'b0;
      r_dat3 <= '0;
      r_sat3 <= 1'b0;
      r_tag3 <= '0;
    end else if (w_rdy3) begin
      r_v3 <= r_v2;
      if (r_v2) begin
        r_dat3 <= w_dat;
        r_sat3 <= w_sat;
        r_tag3 <= r_tag2;
      end
    end
  end

  assign out_valid = r_v3;
  assign out_data  = r_dat3;
  assign out_tag   = r_tag3;
  assign out_sat   = r_sat3;

endmodule
